rt_access_ctrl: RTL and testbench

Sequencer that turns single-word access requests into the multi-cycle current and field sequence required by the racetrack logic-in-memory array (RT_block-class array: NMU units of Nr-bit racetracks, Nb word lines, Np positions). It accepts one request at a time over a req/gnt handshake, drives word-line select, write enables, pNML clock phases (Bz_m/Bz_s with matching currents) and the read strobe, then captures the array output and returns it with a one-cycle valid pulse. It sits between the core-side LiM memory port and the racetrack array.

---
 rtl/rt_access_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_rt_access_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_access_ctrl.sv
// Request sequencer for a racetrack logic-in-memory array.
// Turns single-word read/write/LiM requests into row, field and current phases.
module rt_access_ctrl #(
  parameter int Nb        = 32,
  parameter int Nr        = 4,
  parameter int NMU       = 8,
  parameter int NSHIFT    = 8,
  parameter int PHASE_CYC = 2,
  localparam int W        = Nr * NMU,
  localparam int AW       = $clog2(Nb)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic [1:0]    op_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          nand_i,
  output logic          gnt_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          rvalid_o,
  output logic [W-1:0]  rdata_o,
  output logic          Bz_m_o,
  output logic          Bz_s_o,
  output logic          current_m_data_o,
  output logic          current_s_data_o,
  output logic          current_m_mask_o,
  output logic          current_s_mask_o,
  output logic          current_m_lim_o,
  output logic          current_s_lim_o,
  output logic          current_read_o,
  output logic [W-1:0]  write_data_o,
  output logic [W-1:0]  write_mask_o,
  output logic          write_en_data_o,
  output logic          write_en_mask_o,
  output logic          IN1_NAND_NORn_o,
  output logic [Nb-1:0] word_lines_o,
  output logic          out_select_o,
  input  logic [W-1:0]  r_data_i
);

  localparam int PW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam int SW = (NSHIFT > 1) ? $clog2(NSHIFT) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, M_PH, S_PH, READ, CAPT, DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_RD = 2'b00, OP_WD = 2'b01, OP_WM = 2'b10, OP_LIM = 2'b11
  } op_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic          nand_q, nand_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;

  logic          bz_m_q, bz_m_d, bz_s_q, bz_s_d;
  logic [2:0]    cur_m_q, cur_m_d, cur_s_q, cur_s_d;
  logic          cur_rd_q, cur_rd_d;
  logic [W-1:0]  wr_data_q, wr_data_d, wr_mask_q, wr_mask_d;
  logic          we_data_q, we_data_d, we_mask_q, we_mask_d;
  logic          nand_sel_q, nand_sel_d, out_sel_q, out_sel_d;
  logic [Nb-1:0] wl_q, wl_d;
  logic          done_q, done_d, rvalid_q, rvalid_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic [2:0]    grp;

  assign gnt_o  = req_i && (state_q == IDLE);
  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    nand_d  = nand_q;
    pcnt_d  = pcnt_q;
    scnt_d  = scnt_q;
    case (state_q)
      IDLE: if (gnt_o) begin
        op_d    = op_e'(op_i);
        addr_d  = addr_i;
        wdata_d = wdata_i;
        nand_d  = nand_i;
        state_d = SETUP;
      end
      SETUP: begin
        pcnt_d  = '0;
        scnt_d  = '0;
        state_d = (op_q == OP_RD) ? READ : M_PH;
      end
      M_PH: if (pcnt_q == PW'(PHASE_CYC - 1)) begin
        pcnt_d  = '0;
        state_d = S_PH;
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
      S_PH: if (pcnt_q == PW'(PHASE_CYC - 1)) begin
        pcnt_d = '0;
        if (scnt_q == SW'(NSHIFT - 1)) begin
          state_d = (op_q == OP_LIM) ? READ : DONE;
        end else begin
          scnt_d  = scnt_q + SW'(1);
          state_d = M_PH;
        end
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
      READ:    state_d = CAPT;
      CAPT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array drives decode the upcoming state so they register in step with it.
  always_comb begin
    grp        = {op_d == OP_LIM, op_d == OP_WM, op_d == OP_WD};
    bz_m_d     = 1'b0;
    bz_s_d     = 1'b0;
    cur_m_d    = '0;
    cur_s_d    = '0;
    cur_rd_d   = 1'b0;
    wr_data_d  = '0;
    wr_mask_d  = '0;
    we_data_d  = 1'b0;
    we_mask_d  = 1'b0;
    nand_sel_d = 1'b0;
    out_sel_d  = 1'b0;
    wl_d       = '0;
    done_d     = 1'b0;
    rvalid_d   = 1'b0;
    rdata_d    = (state_q == CAPT) ? r_data_i : rdata_q;
    if (state_d != IDLE) begin
      if (int'(addr_d) < Nb) wl_d[addr_d] = 1'b1;
      out_sel_d  = (op_d == OP_LIM);
      nand_sel_d = (op_d == OP_LIM) && nand_d;
    end
    case (state_d)
      SETUP: begin
        we_data_d = (op_d == OP_WD);
        we_mask_d = (op_d == OP_WM);
        if (op_d == OP_WD) wr_data_d = wdata_d;
        if (op_d == OP_WM) wr_mask_d = wdata_d;
      end
      M_PH: begin
        bz_m_d  = 1'b1;
        cur_m_d = grp;
      end
      S_PH: begin
        bz_s_d  = 1'b1;
        cur_s_d = grp;
      end
      READ: cur_rd_d = 1'b1;
      DONE: begin
        done_d   = 1'b1;
        rvalid_d = (op_d == OP_RD) || (op_d == OP_LIM);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= OP_RD;
      addr_q     <= '0;
      wdata_q    <= '0;
      nand_q     <= 1'b0;
      pcnt_q     <= '0;
      scnt_q     <= '0;
      bz_m_q     <= 1'b0;
      bz_s_q     <= 1'b0;
      cur_m_q    <= '0;
      cur_s_q    <= '0;
      cur_rd_q   <= 1'b0;
      wr_data_q  <= '0;
      wr_mask_q  <= '0;
      we_data_q  <= 1'b0;
      we_mask_q  <= 1'b0;
      nand_sel_q <= 1'b0;
      out_sel_q  <= 1'b0;
      wl_q       <= '0;
      done_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      nand_q     <= nand_d;
      pcnt_q     <= pcnt_d;
      scnt_q     <= scnt_d;
      bz_m_q     <= bz_m_d;
      bz_s_q     <= bz_s_d;
      cur_m_q    <= cur_m_d;
      cur_s_q    <= cur_s_d;
      cur_rd_q   <= cur_rd_d;
      wr_data_q  <= wr_data_d;
      wr_mask_q  <= wr_mask_d;
      we_data_q  <= we_data_d;
      we_mask_q  <= we_mask_d;
      nand_sel_q <= nand_sel_d;
      out_sel_q  <= out_sel_d;
      wl_q       <= wl_d;
      done_q     <= done_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign Bz_m_o           = bz_m_q;
  assign Bz_s_o           = bz_s_q;
  assign current_m_data_o = cur_m_q[0];
  assign current_m_mask_o = cur_m_q[1];
  assign current_m_lim_o  = cur_m_q[2];
  assign current_s_data_o = cur_s_q[0];
  assign current_s_mask_o = cur_s_q[1];
  assign current_s_lim_o  = cur_s_q[2];
  assign current_read_o   = cur_rd_q;
  assign write_data_o     = wr_data_q;
  assign write_mask_o     = wr_mask_q;
  assign write_en_data_o  = we_data_q;
  assign write_en_mask_o  = we_mask_q;
  assign IN1_NAND_NORn_o  = nand_sel_q;
  assign out_select_o     = out_sel_q;
  assign word_lines_o     = wl_q;
  assign done_o           = done_q;
  assign rvalid_o         = rvalid_q;
  assign rdata_o          = rdata_q;

endmodule

// File: tb/tb_rt_access_ctrl.sv
// Directed-vector bench for rt_access_ctrl (default build plus a
// PHASE_CYC=1 / NSHIFT=1 build).
module tb_rt_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic        req = 0, nand_s = 0;
  logic [1:0]  op = 0;
  logic [4:0]  addr = 0;
  logic [31:0] wdata = 0, r_data = 0;

  logic        gnt_o, busy_o, done_o, rvalid_o;
  logic [31:0] rdata_o, write_data_o, write_mask_o, word_lines_o;
  logic        Bz_m_o, Bz_s_o, current_read_o;
  logic        current_m_data_o, current_s_data_o;
  logic        current_m_mask_o, current_s_mask_o;
  logic        current_m_lim_o, current_s_lim_o;
  logic        write_en_data_o, write_en_mask_o;
  logic        IN1_NAND_NORn_o, out_select_o;

  rt_access_ctrl dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op),
    .addr_i(addr), .wdata_i(wdata), .nand_i(nand_s),
    .gnt_o(gnt_o), .busy_o(busy_o), .done_o(done_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .Bz_m_o(Bz_m_o), .Bz_s_o(Bz_s_o),
    .current_m_data_o(current_m_data_o),
    .current_s_data_o(current_s_data_o),
    .current_m_mask_o(current_m_mask_o),
    .current_s_mask_o(current_s_mask_o),
    .current_m_lim_o(current_m_lim_o),
    .current_s_lim_o(current_s_lim_o),
    .current_read_o(current_read_o),
    .write_data_o(write_data_o), .write_mask_o(write_mask_o),
    .write_en_data_o(write_en_data_o),
    .write_en_mask_o(write_en_mask_o),
    .IN1_NAND_NORn_o(IN1_NAND_NORn_o),
    .word_lines_o(word_lines_o), .out_select_o(out_select_o),
    .r_data_i(r_data)
  );

  logic        t_req = 0;
  logic [1:0]  t_op = 0;
  logic        t_gnt, t_busy, t_done, t_rvalid;
  logic [31:0] t_rdata, t_wd, t_wm, t_wl;
  logic        t_bzm, t_bzs, t_rd, t_md, t_sd, t_mm, t_sm;
  logic        t_ml, t_sl, t_wed, t_wem, t_nand, t_osel;

  rt_access_ctrl #(.PHASE_CYC(1), .NSHIFT(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(t_req), .op_i(t_op),
    .addr_i(5'd2), .wdata_i(32'h0000_00FF), .nand_i(1'b0),
    .gnt_o(t_gnt), .busy_o(t_busy), .done_o(t_done),
    .rvalid_o(t_rvalid), .rdata_o(t_rdata),
    .Bz_m_o(t_bzm), .Bz_s_o(t_bzs),
    .current_m_data_o(t_md), .current_s_data_o(t_sd),
    .current_m_mask_o(t_mm), .current_s_mask_o(t_sm),
    .current_m_lim_o(t_ml), .current_s_lim_o(t_sl),
    .current_read_o(t_rd),
    .write_data_o(t_wd), .write_mask_o(t_wm),
    .write_en_data_o(t_wed), .write_en_mask_o(t_wem),
    .IN1_NAND_NORn_o(t_nand),
    .word_lines_o(t_wl), .out_select_o(t_osel),
    .r_data_i(32'h0)
  );

  wire any_out = |{gnt_o, busy_o, done_o, rvalid_o, rdata_o,
    Bz_m_o, Bz_s_o, current_m_data_o, current_s_data_o,
    current_m_mask_o, current_s_mask_o, current_m_lim_o,
    current_s_lim_o, current_read_o, write_data_o,
    write_mask_o, write_en_data_o, write_en_mask_o,
    IN1_NAND_NORn_o, word_lines_o, out_select_o};

  wire [2:0] groups = {current_m_data_o | current_s_data_o,
    current_m_mask_o | current_s_mask_o,
    current_m_lim_o | current_s_lim_o};

  // Field-phase and current-group exclusivity watched every cycle.
  always @(negedge clk) begin
    checks++;
    if ((Bz_m_o & Bz_s_o) !== 1'b0) begin
      fails++;
      $display("FAIL bz_exclusive: Bz_m=%b Bz_s=%b need not both 1",
               Bz_m_o, Bz_s_o);
    end
    checks++;
    if ((groups & (groups - 3'd1)) !== 3'd0) begin
      fails++;
      $display("FAIL one_group: groups=%b need at most one", groups);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if (any_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: any_out=%b need 0", any_out);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    req = 1; op = 2'b00; addr = 5'd5; r_data = 32'hA5A5_1234;
    #1;
    checks++;
    if (gnt_o !== 1'b1) begin
      fails++;
      $display("FAIL rd_gnt: got %b need 1", gnt_o);
    end
    for (int c = 1; c <= 5; c++) begin
      step();
      req = 0;
      checks++;
      if (word_lines_o !== ((c <= 4) ? 32'h20 : 32'h0)) begin
        fails++;
        $display("FAIL rd_wl c%0d: got %h", c, word_lines_o);
      end
      checks++;
      if (current_read_o !== (c == 2)) begin
        fails++;
        $display("FAIL rd_strobe c%0d: got %b", c, current_read_o);
      end
      checks++;
      if ({done_o, rvalid_o} !== {2{c == 4}}) begin
        fails++;
        $display("FAIL rd_done c%0d: got %b%b", c, done_o, rvalid_o);
      end
      checks++;
      if (busy_o !== (c <= 4)) begin
        fails++;
        $display("FAIL rd_busy c%0d: got %b", c, busy_o);
      end
    end
    checks++;
    if (rdata_o !== 32'hA5A5_1234) begin
      fails++;
      $display("FAIL rd_data: got %h need a5a51234", rdata_o);
    end
  endtask

  task automatic test_write();
    int mp = 0, mh = 0, sp = 0, sh = 0;
    logic pm = 0, ps = 0;
    req = 1; op = 2'b01; addr = 5'd31; wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 35; c++) begin
      step();
      req = 0;
      if (Bz_m_o && !pm) mp++;
      if (Bz_s_o && !ps) sp++;
      if (Bz_m_o) mh++;
      if (Bz_s_o) sh++;
      pm = Bz_m_o;
      ps = Bz_s_o;
      checks++;
      if (write_en_data_o !== (c == 1) ||
          write_data_o !== ((c == 1) ? 32'hDEAD_BEEF : 32'h0)) begin
        fails++;
        $display("FAIL wr_en c%0d: en=%b bus=%h", c,
                 write_en_data_o, write_data_o);
      end
      checks++;
      if (done_o !== (c == 34) || rvalid_o !== 1'b0) begin
        fails++;
        $display("FAIL wr_done c%0d: done=%b rvalid=%b", c,
                 done_o, rvalid_o);
      end
      checks++;
      if (word_lines_o !== ((c <= 34) ? 32'h8000_0000 : 32'h0)) begin
        fails++;
        $display("FAIL wr_wl c%0d: got %h", c, word_lines_o);
      end
    end
    checks++;
    if (mp != 8 || sp != 8 || mh != 16 || sh != 16) begin
      fails++;
      $display("FAIL wr_pulses: m=%0d/%0d s=%0d/%0d need 8/16",
               mp, mh, sp, sh);
    end
  endtask

  task automatic test_lim();
    logic em, es;
    req = 1; op = 2'b11; addr = 5'd0; nand_s = 0;
    r_data = 32'h0F0F_00FF;
    for (int c = 1; c <= 37; c++) begin
      step();
      req = 0;
      em = (c >= 2 && c <= 33 && ((c - 2) % 4) < 2);
      es = (c >= 2 && c <= 33 && ((c - 2) % 4) >= 2);
      checks++;
      if (out_select_o !== (c <= 36) || IN1_NAND_NORn_o !== 1'b0) begin
        fails++;
        $display("FAIL lim_sel c%0d: osel=%b nand=%b", c,
                 out_select_o, IN1_NAND_NORn_o);
      end
      checks++;
      if (current_m_lim_o !== em || current_s_lim_o !== es ||
          Bz_m_o !== em || Bz_s_o !== es) begin
        fails++;
        $display("FAIL lim_phase c%0d: ml=%b sl=%b bm=%b bs=%b", c,
                 current_m_lim_o, current_s_lim_o, Bz_m_o, Bz_s_o);
      end
      checks++;
      if (current_read_o !== (c == 34) || rvalid_o !== (c == 36)) begin
        fails++;
        $display("FAIL lim_rd c%0d: rd=%b rvalid=%b", c,
                 current_read_o, rvalid_o);
      end
    end
    checks++;
    if (rdata_o !== 32'h0F0F_00FF) begin
      fails++;
      $display("FAIL lim_data: got %h need 0f0f00ff", rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    req = 1; op = 2'b01; addr = 5'd3; wdata = 32'h1111_1111;
    for (int c = 1; c <= 36; c++) begin
      step();
      if (c == 1) begin
        op = 2'b10; addr = 5'd7; wdata = 32'h2222_2222;
        #1;
      end
      checks++;
      if (gnt_o !== (c == 35)) begin
        fails++;
        $display("FAIL b2b_gnt c%0d: got %b", c, gnt_o);
      end
      if (c == 1) begin
        checks++;
        if (write_data_o !== 32'h1111_1111 || write_en_mask_o !== 1'b0) begin
          fails++;
          $display("FAIL b2b_latch: bus=%h enm=%b", write_data_o,
                   write_en_mask_o);
        end
      end
      if (c == 2) begin
        checks++;
        if (current_m_data_o !== 1'b1 || current_m_mask_o !== 1'b0) begin
          fails++;
          $display("FAIL b2b_cur: md=%b mm=%b", current_m_data_o,
                   current_m_mask_o);
        end
      end
    end
    req = 0;
    checks++;
    if (write_en_mask_o !== 1'b1 || write_mask_o !== 32'h2222_2222 ||
        word_lines_o !== 32'h80) begin
      fails++;
      $display("FAIL b2b_second: en=%b bus=%h wl=%h", write_en_mask_o,
               write_mask_o, word_lines_o);
    end
    while (done_o !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    checks++;
    if (k != 33) begin
      fails++;
      $display("FAIL b2b_done: %0d cycles after setup need 33", k);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    int dn = 0;
    req = 1; op = 2'b01; addr = 5'd9; wdata = 32'h1234_5678;
    for (int c = 1; c <= 6; c++) begin
      step();
      req = 0;
    end
    checks++;
    if (Bz_m_o !== 1'b1) begin
      fails++;
      $display("FAIL mid_phase: Bz_m=%b need 1", Bz_m_o);
    end
    rst = 1;
    #1;
    checks++;
    if (any_out !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: any_out=%b need 0", any_out);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      if (done_o) dn++;
    end
    rst = 0;
    req = 1; op = 2'b00; addr = 5'd1; r_data = 32'h0BAD_F00D;
    #1;
    checks++;
    if (gnt_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_regrant: got %b need 1", gnt_o);
    end
    for (int c = 1; c <= 4; c++) begin
      step();
      req = 0;
      if (c < 4 && done_o) dn++;
    end
    checks++;
    if (dn != 0 || done_o !== 1'b1 || rdata_o !== 32'h0BAD_F00D) begin
      fails++;
      $display("FAIL rst_followup: stray=%0d done=%b data=%h", dn,
               done_o, rdata_o);
    end
    step();
  endtask

  task automatic test_sweep();
    t_req = 1; t_op = 2'b01;
    #1;
    checks++;
    if (t_gnt !== 1'b1) begin
      fails++;
      $display("FAIL sw_gnt: got %b need 1", t_gnt);
    end
    for (int c = 1; c <= 5; c++) begin
      step();
      t_req = 0;
      checks++;
      if (t_done !== (c == 4) || t_bzm !== (c == 2) ||
          t_bzs !== (c == 3) || t_md !== (c == 2)) begin
        fails++;
        $display("FAIL sw_seq c%0d: done=%b bm=%b bs=%b md=%b", c,
                 t_done, t_bzm, t_bzs, t_md);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_lim();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
